// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: oldest-first selection per issue port,
// per-port occupancy tracking for non-pipelined ops, and ROB-window squash.

// Per-port state: registered issue slot plus occupancy counter for multi-cycle ops.
module rs_port_slot #(
    parameter int ROB_W = 5,
    parameter int LAT_W = 3,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             i_sel,
    input  logic [IDX_W-1:0] i_sel_idx,
    input  logic [ROB_W-1:0] i_sel_rob,
    input  logic [LAT_W-1:0] i_sel_lat,
    input  logic             i_occ_sq,
    output logic [ROB_W-1:0] o_occ_rob,
    output logic             o_busy,
    output logic             o_iss_valid,
    output logic [IDX_W-1:0] o_iss_idx,
    output logic [ROB_W-1:0] o_iss_rob
);
    logic [LAT_W-1:0] r_cnt;
    logic [ROB_W-1:0] r_occ_rob;
    logic             r_iss_valid;
    logic [IDX_W-1:0] r_iss_idx;
    logic [ROB_W-1:0] r_iss_rob;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_occ_rob   <= '0;
            r_iss_valid <= 1'b0;
            r_iss_idx   <= '0;
            r_iss_rob   <= '0;
        end else if (en) begin
            // A squashed op on the issue slot is dropped simply by not reloading it.
            r_iss_valid <= i_sel;
            if (i_sel) begin
                r_iss_idx <= i_sel_idx;
                r_iss_rob <= i_sel_rob;
            end
            if (i_occ_sq && (r_cnt != '0)) begin
                r_cnt <= '0;
            end else if (i_sel) begin
                if (i_sel_lat > LAT_W'(1)) begin
                    r_cnt     <= LAT_W'(i_sel_lat - LAT_W'(1));
                    r_occ_rob <= i_sel_rob;
                end else begin
                    r_cnt <= '0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= LAT_W'(r_cnt - LAT_W'(1));
            end
        end
    end

    assign o_occ_rob   = r_occ_rob;
    assign o_busy      = (r_cnt != '0);
    assign o_iss_valid = r_iss_valid;
    assign o_iss_idx   = r_iss_idx;
    assign o_iss_rob   = r_iss_rob;
endmodule

module rs_issue_sched #(
    parameter int NUM_ENTRY = 8,
    parameter int NUM_PORT  = 2,
    parameter int ROB_W     = 5,
    parameter int LAT_W     = 3,
    localparam int IDX_W    = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [NUM_ENTRY-1:0]                 req_valid,
    input  logic [NUM_ENTRY-1:0][ROB_W-1:0]      req_ROB_idx,
    input  logic [NUM_ENTRY-1:0][NUM_PORT-1:0]   req_port_mask,
    input  logic [NUM_ENTRY-1:0][LAT_W-1:0]      req_lat,
    input  logic [ROB_W-1:0]                     ROB_head_idx,
    input  logic                                 rollback_en,
    input  logic [ROB_W-1:0]                     ROB_rollback_idx,
    input  logic [ROB_W-1:0]                     diff_ROB,
    output logic [NUM_ENTRY-1:0]                 grant,
    output logic [NUM_PORT-1:0]                  iss_valid,
    output logic [NUM_PORT-1:0][IDX_W-1:0]       iss_entry_idx,
    output logic [NUM_PORT-1:0][ROB_W-1:0]       iss_ROB_idx,
    output logic [NUM_PORT-1:0]                  port_busy
);
    // Window membership is modular so it stays correct across ROB wrap-around.
    function automatic logic sq_f(input logic [ROB_W-1:0] x);
        logic [ROB_W-1:0] d;
        d = x - ROB_rollback_idx;
        return rollback_en && (d <= diff_ROB);
    endfunction

    logic [NUM_ENTRY-1:0]               w_sq;
    logic [NUM_ENTRY-1:0][ROB_W-1:0]    w_age;
    logic [NUM_ENTRY-1:0]               w_taken;
    logic [NUM_PORT-1:0]                w_free;
    logic [NUM_PORT-1:0]                w_sel_vld;
    logic [NUM_PORT-1:0][IDX_W-1:0]     w_sel_idx;
    logic [NUM_PORT-1:0][ROB_W-1:0]     w_sel_rob;
    logic [NUM_PORT-1:0][LAT_W-1:0]     w_sel_lat;
    logic [NUM_PORT-1:0][ROB_W-1:0]     w_best;
    logic [NUM_PORT-1:0][ROB_W-1:0]     w_occ_rob;
    logic [NUM_PORT-1:0]                w_occ_sq;

    always_comb begin
        w_sq  = '0;
        w_age = '0;
        for (int e = 0; e < NUM_ENTRY; e++) begin
            w_sq[e]  = sq_f(req_ROB_idx[e]);
            w_age[e] = req_ROB_idx[e] - ROB_head_idx;
        end
    end

    // Ports pick in order; strict '<' keeps the lower entry index on equal age.
    always_comb begin
        w_taken   = '0;
        w_sel_vld = '0;
        w_sel_idx = '0;
        w_sel_rob = '0;
        w_sel_lat = '0;
        w_best    = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int e = 0; e < NUM_ENTRY; e++) begin
                if (w_free[p] && req_valid[e] && req_port_mask[e][p] && !w_sq[e] &&
                    !w_taken[e] && (!w_sel_vld[p] || (w_age[e] < w_best[p]))) begin
                    w_sel_vld[p] = 1'b1;
                    w_sel_idx[p] = IDX_W'(e);
                    w_sel_rob[p] = req_ROB_idx[e];
                    w_sel_lat[p] = req_lat[e];
                    w_best[p]    = w_age[e];
                end
            end
            for (int e = 0; e < NUM_ENTRY; e++) begin
                if (w_sel_vld[p] && (w_sel_idx[p] == IDX_W'(e))) w_taken[e] = 1'b1;
            end
        end
    end

    assign grant = en ? w_taken : '0;

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
        assign w_free[p]   = !port_busy[p];
        assign w_occ_sq[p] = sq_f(w_occ_rob[p]);

        rs_port_slot #(.ROB_W(ROB_W), .LAT_W(LAT_W), .IDX_W(IDX_W)) u_slot (
            .clock       (clock),
            .reset       (reset),
            .en          (en),
            .i_sel       (w_sel_vld[p]),
            .i_sel_idx   (w_sel_idx[p]),
            .i_sel_rob   (w_sel_rob[p]),
            .i_sel_lat   (w_sel_lat[p]),
            .i_occ_sq    (w_occ_sq[p]),
            .o_occ_rob   (w_occ_rob[p]),
            .o_busy      (port_busy[p]),
            .o_iss_valid (iss_valid[p]),
            .o_iss_idx   (iss_entry_idx[p]),
            .o_iss_rob   (iss_ROB_idx[p])
        );
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: vector table for single-cycle arbitration,
// hand sequences for occupancy, rollback, stall and reset behaviour.
module tb_rs_issue_sched;
    localparam int NE = 8, NP = 2, RW = 5, LW = 3, IW = 3;

    logic                    clock = 1'b0;
    logic                    reset, en;
    logic [NE-1:0]           req_valid;
    logic [NE-1:0][RW-1:0]   req_ROB_idx;
    logic [NE-1:0][NP-1:0]   req_port_mask;
    logic [NE-1:0][LW-1:0]   req_lat;
    logic [RW-1:0]           ROB_head_idx, ROB_rollback_idx, diff_ROB;
    logic                    rollback_en;
    logic [NE-1:0]           grant;
    logic [NP-1:0]           iss_valid, port_busy;
    logic [NP-1:0][IW-1:0]   iss_entry_idx;
    logic [NP-1:0][RW-1:0]   iss_ROB_idx;

    rs_issue_sched #(.NUM_ENTRY(NE), .NUM_PORT(NP), .ROB_W(RW), .LAT_W(LW)) dut (
        .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
        .req_ROB_idx(req_ROB_idx), .req_port_mask(req_port_mask), .req_lat(req_lat),
        .ROB_head_idx(ROB_head_idx), .rollback_en(rollback_en),
        .ROB_rollback_idx(ROB_rollback_idx), .diff_ROB(diff_ROB), .grant(grant),
        .iss_valid(iss_valid), .iss_entry_idx(iss_entry_idx), .iss_ROB_idx(iss_ROB_idx),
        .port_busy(port_busy)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NE-1:0]         vld;
        logic [NE-1:0][RW-1:0] rob;
        logic [NE-1:0][NP-1:0] mask;
        logic [RW-1:0]         head;
        logic                  rb_en;
        logic [RW-1:0]         rb_idx, diff;
        logic [NE-1:0]         exp_g;
        logic [NP-1:0]         exp_iv;
        logic [NP-1:0][IW-1:0] exp_idx;
        logic [NP-1:0][RW-1:0] exp_rob;
    } vec_t;

    vec_t vt[7];

    task automatic clr_in();
        req_valid = '0; req_ROB_idx = '0; req_port_mask = '0; req_lat = '0;
        ROB_head_idx = '0; rollback_en = 1'b0; ROB_rollback_idx = '0; diff_ROB = '0;
        en = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clr_in();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) vt[i] = '{default: '0};
        // two ready entries on both ports: older ROB goes to port 0
        vt[0].vld = 8'h24; vt[0].rob[2] = 7; vt[0].rob[5] = 3;
        vt[0].mask[2] = 2'b11; vt[0].mask[5] = 2'b11;
        vt[0].exp_g = 8'h24; vt[0].exp_iv = 2'b11;
        vt[0].exp_idx[0] = 5; vt[0].exp_rob[0] = 3; vt[0].exp_idx[1] = 2; vt[0].exp_rob[1] = 7;
        // nothing ready
        vt[1].exp_g = 8'h00; vt[1].exp_iv = 2'b00;
        // head 30: ROB 31 (age 1) beats ROB 1 (age 3)
        vt[2].vld = 8'h03; vt[2].rob[0] = 1; vt[2].rob[1] = 31; vt[2].head = 30;
        vt[2].mask[0] = 2'b01; vt[2].mask[1] = 2'b01;
        vt[2].exp_g = 8'h02; vt[2].exp_iv = 2'b01; vt[2].exp_idx[0] = 1; vt[2].exp_rob[0] = 31;
        // equal age: lower entry wins
        vt[3].vld = 8'h48; vt[3].rob[3] = 4; vt[3].rob[6] = 4;
        vt[3].mask[3] = 2'b01; vt[3].mask[6] = 2'b01;
        vt[3].exp_g = 8'h08; vt[3].exp_iv = 2'b01; vt[3].exp_idx[0] = 3; vt[3].exp_rob[0] = 4;
        // port mask steers older entry to port 1
        vt[4].vld = 8'h03; vt[4].rob[0] = 0; vt[4].rob[1] = 5;
        vt[4].mask[0] = 2'b10; vt[4].mask[1] = 2'b01;
        vt[4].exp_g = 8'h03; vt[4].exp_iv = 2'b11;
        vt[4].exp_idx[0] = 1; vt[4].exp_rob[0] = 5; vt[4].exp_idx[1] = 0; vt[4].exp_rob[1] = 0;
        // rollback window 8..12: only ROB 13 survives
        vt[5].vld = 8'h0F; vt[5].rob[0] = 10; vt[5].rob[1] = 13; vt[5].rob[2] = 8; vt[5].rob[3] = 12;
        for (int e = 0; e < 4; e++) vt[5].mask[e] = 2'b11;
        vt[5].rb_en = 1; vt[5].rb_idx = 8; vt[5].diff = 4;
        vt[5].exp_g = 8'h02; vt[5].exp_iv = 2'b01; vt[5].exp_idx[0] = 1; vt[5].exp_rob[0] = 13;
        // wrapped rollback window 30..1, head 28: ROB 29 then ROB 2 survive
        vt[6].vld = 8'h0F; vt[6].rob[0] = 31; vt[6].rob[1] = 2; vt[6].rob[2] = 0; vt[6].rob[3] = 29;
        for (int e = 0; e < 4; e++) vt[6].mask[e] = 2'b11;
        vt[6].head = 28; vt[6].rb_en = 1; vt[6].rb_idx = 30; vt[6].diff = 3;
        vt[6].exp_g = 8'h0A; vt[6].exp_iv = 2'b11;
        vt[6].exp_idx[0] = 3; vt[6].exp_rob[0] = 29; vt[6].exp_idx[1] = 1; vt[6].exp_rob[1] = 2;

        clr_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_port_busy", 32'(port_busy), 0);
        chk("rst_iss_idx", 32'(iss_entry_idx), 0);
        chk("rst_iss_rob", 32'(iss_ROB_idx), 0);
        chk("rst_grant", 32'(grant), 0);

        for (int i = 0; i < 7; i++) begin
            clr_in();
            req_valid = vt[i].vld; req_ROB_idx = vt[i].rob; req_port_mask = vt[i].mask;
            for (int e = 0; e < NE; e++) req_lat[e] = 3'd1;
            ROB_head_idx = vt[i].head; rollback_en = vt[i].rb_en;
            ROB_rollback_idx = vt[i].rb_idx; diff_ROB = vt[i].diff;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].exp_g));
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("v%0d_iss_valid", i), 32'(iss_valid), 32'(vt[i].exp_iv));
            for (int p = 0; p < NP; p++) begin
                if (vt[i].exp_iv[p]) begin
                    chk($sformatf("v%0d_p%0d_idx", i, p), 32'(iss_entry_idx[p]), 32'(vt[i].exp_idx[p]));
                    chk($sformatf("v%0d_p%0d_rob", i, p), 32'(iss_ROB_idx[p]), 32'(vt[i].exp_rob[p]));
                end
            end
        end

        // lat 4 on port 1 blocks a second port-1 entry for three cycles
        do_reset();
        req_valid = 8'h01; req_ROB_idx[0] = 1; req_port_mask[0] = 2'b10; req_lat[0] = 4;
        #1 chk("occ_first_grant", 32'(grant), 32'h01);
        @(posedge clock);
        @(negedge clock);
        req_valid = 8'h02; req_ROB_idx[1] = 2; req_port_mask[1] = 2'b10; req_lat[1] = 1;
        chk("occ_iss_valid", 32'(iss_valid), 32'b10);
        chk("occ_iss_rob", 32'(iss_ROB_idx[1]), 1);
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk($sformatf("occ_busy_c%0d", k), 32'(port_busy), 32'b10);
            chk($sformatf("occ_grant_c%0d", k), 32'(grant), 0);
            @(posedge clock);
            @(negedge clock);
        end
        chk("occ_busy_free", 32'(port_busy), 0);
        chk("occ_second_grant", 32'(grant), 32'h02);
        @(posedge clock);
        @(negedge clock);
        chk("occ_second_iss", 32'(iss_valid), 32'b10);
        chk("occ_second_idx", 32'(iss_entry_idx[1]), 1);

        // rollback squashes the op occupying port 1 and a ready younger entry
        do_reset();
        req_valid = 8'h01; req_ROB_idx[0] = 9; req_port_mask[0] = 2'b10; req_lat[0] = 4;
        @(posedge clock);
        @(negedge clock);
        req_valid = 8'h02; req_ROB_idx[1] = 10; req_port_mask[1] = 2'b11; req_lat[1] = 1;
        rollback_en = 1; ROB_rollback_idx = 8; diff_ROB = 4;
        #1;
        chk("rb_busy_before", 32'(port_busy), 32'b10);
        chk("rb_grant_squashed", 32'(grant), 0);
        @(posedge clock);
        @(negedge clock);
        rollback_en = 0;
        #1;
        chk("rb_busy_cleared", 32'(port_busy), 0);
        chk("rb_iss_cleared", 32'(iss_valid), 0);
        chk("rb_grant_after", 32'(grant), 32'h02);

        // stall for three cycles with ready entries, then release
        do_reset();
        req_valid = 8'h04; req_ROB_idx[2] = 7; req_port_mask[2] = 2'b10; req_lat[2] = 4;
        @(posedge clock);
        @(negedge clock);
        en = 0;
        req_valid = 8'h03; req_ROB_idx[0] = 5; req_ROB_idx[1] = 3;
        req_port_mask[0] = 2'b01; req_port_mask[1] = 2'b01; req_lat[0] = 1; req_lat[1] = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_grant_c%0d", k), 32'(grant), 0);
            chk($sformatf("stall_iss_c%0d", k), 32'(iss_valid), 32'b10);
            chk($sformatf("stall_rob_c%0d", k), 32'(iss_ROB_idx[1]), 7);
            chk($sformatf("stall_busy_c%0d", k), 32'(port_busy), 32'b10);
            @(posedge clock);
            @(negedge clock);
        end
        en = 1;
        #1 chk("stall_release_grant", 32'(grant), 32'h02);
        @(posedge clock);
        @(negedge clock);
        chk("stall_release_iss", 32'(iss_valid), 32'b01);
        chk("stall_release_idx", 32'(iss_entry_idx[0]), 1);
        chk("stall_release_busy", 32'(port_busy), 32'b10);

        // reset mid-occupancy
        do_reset();
        req_valid = 8'h01; req_ROB_idx[0] = 4; req_port_mask[0] = 2'b01; req_lat[0] = 3;
        @(posedge clock);
        @(negedge clock);
        chk("mrst_pre_busy", 32'(port_busy), 32'b01);
        chk("mrst_pre_iss", 32'(iss_valid), 32'b01);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("mrst_iss_valid", 32'(iss_valid), 0);
        chk("mrst_busy", 32'(port_busy), 0);
        chk("mrst_idx", 32'(iss_entry_idx), 0);
        chk("mrst_rob", 32'(iss_ROB_idx), 0);
        req_valid = 8'h08; req_ROB_idx[3] = 6; req_port_mask[3] = 2'b01; req_lat[3] = 1;
        #1 chk("mrst_grant", 32'(grant), 32'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
